sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synthesizable, clocked responder for the external 16-bit SRAM pin interface that our SRAM controller drives.
- Lets the controller run against on-chip storage in FPGA bring-up and in simulation without the board SRAM.
- Decodes CE_N/WE_N/OE_N/UB_N/LB_N with byte-lane writes.
- Returns read data on SRAM_DQ after a programmable latency, and tristates SRAM_DQ otherwise.

Parameters:
- ADDR_W, 18, width of SRAM_ADDR.
- DEPTH_W, 10, implemented words = 2**DEPTH_W. Only SRAM_ADDR[DEPTH_W-1:0] is decoded; upper bits alias.
- READ_LAT, 2, cycles from read sample to DQ drive. Legal range 1..15.

Ports:
- clk  in  1  system clock, all sampling on rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_DQ  inout  16  data bus; driven only in DRIVE, otherwise high-Z.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_UB_N  in  1  upper byte enable [15:8], active-low.
- SRAM_LB_N  in  1  lower byte enable [7:0], active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- ready  out  1  high when accesses are accepted.
- wr_cnt  out  16  count of accepted write cycles, wraps.
- rd_cnt  out  16  count of entries into DRIVE, wraps.

Behaviour:
- Reset (rst=0, async):
  - State IDLE, lat counter 0, SRAM_DQ high-Z immediately.
  - ready=1, wr_cnt=0, rd_cnt=0.
  - Memory contents are not cleared unless the optional feature is compiled in.
- Write:
  - Occurs at any posedge with CE_N=0 and WE_N=0 (OE_N ignored).
  - Lower byte written if LB_N=0; upper byte written if UB_N=0. Both high: no write, wr_cnt still increments.
  - A write forces the state to IDLE.
  - Write data is visible to a read sampled on the next posedge.
- Read FSM (IDLE, WAIT, DRIVE):
  - IDLE -> WAIT: at a posedge with CE_N=0, WE_N=1, OE_N=0. Latch addr; lat counter = READ_LAT-1.
  - WAIT: counter decrements each cycle. WAIT -> DRIVE when the counter is 0 and the access condition still holds with addr equal to the latch. rd_cnt increments on this transition.
  - WAIT, any address change: relatch addr and reload the counter (stay in WAIT).
  - DRIVE: SRAM_DQ = mem[latched addr]. Byte lanes with UB_N/LB_N=1 are high-Z per byte.
  - DRIVE, address change: -> WAIT with reload.
  - WAIT or DRIVE, CE_N=1 or OE_N=1: -> IDLE.
- Bus-contention guard: the DQ output enable is combinationally gated by state==DRIVE & !CE_N & !OE_N & WE_N. WE_N falling releases the bus in the same cycle, before the clock edge.
- Latency: with READ_LAT=L and a stable address from cycle 0, DQ is valid from cycle L after the sampling edge.
- ready=1 in every state except CLEAR (optional feature).
- Read-after-write to the same address returns the new data.

Optional Feature:
- Macro SRAM_RESP_INIT_EN.
- Defined:
  - Reset release enters state CLEAR, which writes 16'h0000 to one word per cycle from address 0 to 2**DEPTH_W-1, then goes to IDLE.
  - ready=0 throughout CLEAR. Pin activity is ignored: no writes, no DQ drive, counters frozen.
  - Reset asserted mid-CLEAR restarts the sweep from 0.
- Undefined: no CLEAR state, ready is constant 1, memory powers up undefined.

Decomposition:
- Package sram_pkg:
  - DQ width 16, ADDR width 18.
  - State enum {IDLE, WAIT, DRIVE, CLEAR}.
  - Lat counter width 4.
- Sub-module sram_byte_array: 2**DEPTH_W x 16 storage with two independent byte write enables and asynchronous read. The FSM, counters and tristate stay in the top level.

Test Plan:
- Full-word write then read: CE_N=0, WE_N=0, UB_N=LB_N=0, ADDR=0x00004, DQ=0xBEEF for one cycle. Then WE_N=1, OE_N=0, READ_LAT=2 -> DQ high-Z for 2 cycles, then 0xBEEF. wr_cnt=1, rd_cnt=1.
- Byte-lane write: over 0xBEEF, write 0x1234 with UB_N=1, LB_N=0 -> read returns 0xBE34. Read with LB_N=1 -> DQ[7:0]=Z, DQ[15:8]=0xBE.
- Address change during read: in WAIT, ADDR 0x4 -> 0x5 one cycle before expiry -> DRIVE is delayed a full READ_LAT from the change and returns mem[0x5]. rd_cnt increments once.
- Write interrupting DRIVE: WE_N falls while in DRIVE -> DQ is Z in the same cycle. State is IDLE after the edge and the write commits.
- Aliasing: DEPTH_W=10, write 0xA5A5 at 0x00400 -> read at 0x00000 returns 0xA5A5.
- Reset mid-read: rst=0 during DRIVE -> DQ is Z asynchronously and counters are 0.
- With SRAM_RESP_INIT_EN: ready=0 for 1024 cycles after reset release, then every address reads 0x0000.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM pin-level responder.
package sram_pkg;

    localparam int SRAM_DQ_W   = 16;
    localparam int SRAM_ADDR_W = 18;
    localparam int LAT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRIVE,
        CLEAR
    } state_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word storage with independent byte write enables and asynchronous read.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic                 clk,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [DEPTH_W-1:0]   waddr,
    input  logic [SRAM_DQ_W-1:0] wdata,
    input  logic [DEPTH_W-1:0]   raddr,
    output logic [SRAM_DQ_W-1:0] rdata
);

    logic [7:0] mem_lo [2**DEPTH_W];
    logic [7:0] mem_hi [2**DEPTH_W];

    // Byte lanes are written independently so partial writes leave the other lane intact.
    always_ff @(posedge clk) begin
        if (we_lo) mem_lo[waddr] <= wdata[7:0];
        if (we_hi) mem_hi[waddr] <= wdata[15:8];
    end

    assign rdata = {mem_hi[raddr], mem_lo[raddr]};

endmodule

// File: rtl/sram_responder.sv
// Clocked responder for the external 16-bit SRAM pin interface.
// Optional build macro SRAM_RESP_INIT_EN adds a post-reset zero-fill sweep (state CLEAR).
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DEPTH_W  = 10,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0]    SRAM_ADDR,
    input  logic                 SRAM_UB_N,
    input  logic                 SRAM_LB_N,
    input  logic                 SRAM_WE_N,
    input  logic                 SRAM_CE_N,
    input  logic                 SRAM_OE_N,
    output logic                 ready,
    output logic [15:0]          wr_cnt,
    output logic [15:0]          rd_cnt
);

    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);

    state_t                 state, state_nxt;
    logic [LAT_W-1:0]       lat_cnt, lat_nxt;
    logic [ADDR_W-1:0]      addr_lat;
    logic                   addr_load;
    logic                   rd_hit;
    logic                   in_clear;
    logic                   wr_acc;
    logic                   rd_req;
    logic                   drive;

    logic                   mem_we_lo, mem_we_hi;
    logic [DEPTH_W-1:0]     mem_waddr;
    logic [SRAM_DQ_W-1:0]   mem_wdata;
    logic [SRAM_DQ_W-1:0]   rdata;

`ifdef SRAM_RESP_INIT_EN
    localparam state_t RST_STATE = CLEAR;
    logic [DEPTH_W-1:0] clr_addr;
    assign in_clear = (state == CLEAR);
    assign ready    = !in_clear;
`else
    localparam state_t RST_STATE = IDLE;
    assign in_clear = 1'b0;
    assign ready    = 1'b1;
`endif

    // Pin activity is ignored while the zero-fill sweep owns the array.
    assign wr_acc = !in_clear && !SRAM_CE_N && !SRAM_WE_N;
    assign rd_req = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

    // Next-state logic: writes preempt any read in progress and return to IDLE.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        addr_load = 1'b0;
        rd_hit    = 1'b0;
        if (in_clear) begin
`ifdef SRAM_RESP_INIT_EN
            if (&clr_addr) state_nxt = IDLE;
`endif
        end else if (wr_acc) begin
            state_nxt = IDLE;
            lat_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state_nxt = WAIT;
                        lat_nxt   = LAT_RELOAD;
                        addr_load = 1'b1;
                    end
                end
                WAIT: begin
                    if (!rd_req) begin
                        state_nxt = IDLE;
                    end else if (SRAM_ADDR != addr_lat) begin
                        lat_nxt   = LAT_RELOAD;
                        addr_load = 1'b1;
                    end else if (lat_cnt == '0) begin
                        state_nxt = DRIVE;
                        rd_hit    = 1'b1;
                    end else begin
                        lat_nxt = lat_cnt - LAT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!rd_req) begin
                        state_nxt = IDLE;
                    end else if (SRAM_ADDR != addr_lat) begin
                        state_nxt = WAIT;
                        lat_nxt   = LAT_RELOAD;
                        addr_load = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control registers: FSM state, latency counter and access counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RST_STATE;
            lat_cnt <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            if (wr_acc) wr_cnt <= wr_cnt + 16'd1;
            if (rd_hit) rd_cnt <= rd_cnt + 16'd1;
        end
    end

`ifdef SRAM_RESP_INIT_EN
    // Sweep pointer restarts from word 0 on every reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          clr_addr <= '0;
        else if (in_clear) clr_addr <= clr_addr + DEPTH_W'(1);
    end
`endif

    // Address latch is pure data; it is only meaningful once a read has been sampled.
    always_ff @(posedge clk) begin
        if (addr_load) addr_lat <= SRAM_ADDR;
    end

    // Array write port: pin writes normally, zero-fill during the sweep.
    always_comb begin
        mem_we_lo = wr_acc && !SRAM_LB_N;
        mem_we_hi = wr_acc && !SRAM_UB_N;
        mem_waddr = SRAM_ADDR[DEPTH_W-1:0];
        mem_wdata = SRAM_DQ;
`ifdef SRAM_RESP_INIT_EN
        if (in_clear) begin
            mem_we_lo = 1'b1;
            mem_we_hi = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    sram_byte_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk   (clk),
        .we_lo (mem_we_lo),
        .we_hi (mem_we_hi),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr_lat[DEPTH_W-1:0]),
        .rdata (rdata)
    );

    // Output enable is combinational so WE_N falling frees the bus before the next edge.
    assign drive = (state == DRIVE) && rd_req;

    assign SRAM_DQ[15:8] = (drive && !SRAM_UB_N) ? rdata[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive && !SRAM_LB_N) ? rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder; optional SRAM_RESP_INIT_EN build also covered.
module tb_sram_responder;

    localparam int L = 2;

    logic        clk;
    logic        rst_n;
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic        tb_drv;
    logic [15:0] tb_data;
    wire  [15:0] dq;
    logic        ready;
    logic [15:0] wr_cnt, rd_cnt;

    int errors;
    int checks;

    // Reference model: memory image, consecutive-read run length, expected counters.
    logic [15:0] mem_m [1024];
    int          run;
    logic [17:0] prev_addr;
    logic [15:0] exp_wr, exp_rd;

`ifdef SRAM_RESP_INIT_EN
    localparam logic EXP_READY_RST = 1'b0;
`else
    localparam logic EXP_READY_RST = 1'b1;
`endif

    assign dq = tb_drv ? tb_data : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq[i]);
    end

    sram_responder #(
        .ADDR_W   (18),
        .DEPTH_W  (10),
        .READ_LAT (L)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .SRAM_DQ   (dq),
        .SRAM_ADDR (addr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .ready     (ready),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected bus value: the word of the last sampled address is driven once the
    // same read has been seen on L+1 consecutive edges; undriven lanes read as pulled-up 1s.
    function automatic logic [15:0] exp_dq();
        logic [15:0] v;
        logic [15:0] m;
        v = 16'hFFFF;
        m = mem_m[prev_addr[9:0]];
        if (run == L + 1 && !ce_n && !oe_n && we_n) begin
            if (!lb_n) v[7:0]  = m[7:0];
            if (!ub_n) v[15:8] = m[15:8];
        end
        return v;
    endfunction

    task automatic model_reset();
        run    = 0;
        exp_wr = 16'd0;
        exp_rd = 16'd0;
`ifdef SRAM_RESP_INIT_EN
        for (int i = 0; i < 1024; i++) mem_m[i] = 16'h0000;
`endif
    endtask

    task automatic model_edge();
        if (!ce_n && !we_n) begin
            if (!lb_n) mem_m[addr[9:0]][7:0]  = tb_data[7:0];
            if (!ub_n) mem_m[addr[9:0]][15:8] = tb_data[15:8];
            exp_wr = exp_wr + 16'd1;
            run    = 0;
        end else if (!ce_n && !oe_n) begin
            if (run > 0 && addr == prev_addr) begin
                if (run == L) begin
                    run    = L + 1;
                    exp_rd = exp_rd + 16'd1;
                end else if (run < L) begin
                    run = run + 1;
                end
            end else begin
                run = 1;
            end
            prev_addr = addr;
        end else begin
            run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_pins();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        ub_n = 1'b0; lb_n = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
        ub_n = ub; lb_n = lb; addr = a;
        tb_drv = 1'b1; tb_data = d;
        step();
        idle_pins();
    endtask

    task automatic start_read(input logic [17:0] a);
        tb_drv = 1'b0;
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
        ub_n = 1'b0; lb_n = 1'b0; addr = a;
    endtask

    task automatic wait_clear();
`ifdef SRAM_RESP_INIT_EN
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1024) begin errors++; $display("FAIL clear_len: got %0d cycles expected 1024", n); end
`endif
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ready !== EXP_READY_RST) begin errors++; $display("FAIL rst_ready: got %b expected %b", ready, EXP_READY_RST); end
        checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL rst_wr_cnt: got %h expected 0000", wr_cnt); end
        checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL rst_rd_cnt: got %h expected 0000", rd_cnt); end
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL rst_dq: got %h expected ffff (released)", dq); end
        rst_n = 1'b1;
        wait_clear();
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", ready); end
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL post_rst_dq: got %h expected ffff", dq); end
    endtask

    task automatic test_full_word();
        do_write(18'h00004, 16'hBEEF, 1'b0, 1'b0);
        checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL fw_wr_cnt: got %h expected 0001", wr_cnt); end
        start_read(18'h00004);
        for (int i = 0; i < L; i++) begin
            step();
            checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL fw_wait_dq: got %h expected ffff", dq); end
        end
        step();
        checks++; if (dq !== 16'hBEEF) begin errors++; $display("FAIL fw_dq: got %h expected beef", dq); end
        checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL fw_rd_cnt: got %h expected 0001", rd_cnt); end
        idle_pins();
        step();
    endtask

    task automatic test_byte_lane();
        do_write(18'h00004, 16'h1234, 1'b1, 1'b0);
        start_read(18'h00004);
        repeat (L + 1) step();
        checks++; if (dq !== 16'hBE34) begin errors++; $display("FAIL bl_dq: got %h expected be34", dq); end
        lb_n = 1'b1;
        #1;
        checks++; if (dq !== 16'hBEFF) begin errors++; $display("FAIL bl_upper_only: got %h expected beff", dq); end
        checks++; if (dq !== exp_dq()) begin errors++; $display("FAIL bl_model: got %h expected %h", dq, exp_dq()); end
        idle_pins();
        step();
    endtask

    task automatic test_addr_change();
        logic [15:0] rd0;
        do_write(18'h00005, 16'h5A5A, 1'b0, 1'b0);
        rd0 = rd_cnt;
        start_read(18'h00004);
        step();
        addr = 18'h00005;
        step();
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL ac_relatch_dq: got %h expected ffff", dq); end
        step();
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL ac_old_expiry_dq: got %h expected ffff", dq); end
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL ac_early_rd_cnt: got %h expected %h", rd_cnt, rd0); end
        step();
        checks++; if (dq !== 16'h5A5A) begin errors++; $display("FAIL ac_dq: got %h expected 5a5a", dq); end
        step();
        checks++; if (rd_cnt !== rd0 + 16'd1) begin errors++; $display("FAIL ac_rd_cnt: got %h expected %h", rd_cnt, rd0 + 16'd1); end
        checks++; if (dq !== exp_dq()) begin errors++; $display("FAIL ac_model: got %h expected %h", dq, exp_dq()); end
    endtask

    task automatic test_write_interrupt();
        logic [15:0] wr0;
        wr0 = wr_cnt;
        we_n = 1'b0;
        #1;
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL wi_release: got %h expected ffff", dq); end
        tb_drv = 1'b1;
        tb_data = 16'h6C3D;
        step();
        we_n = 1'b1;
        tb_drv = 1'b0;
        #1;
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL wi_idle_dq: got %h expected ffff", dq); end
        checks++; if (wr_cnt !== wr0 + 16'd1) begin errors++; $display("FAIL wi_wr_cnt: got %h expected %h", wr_cnt, wr0 + 16'd1); end
        repeat (L + 1) step();
        checks++; if (dq !== 16'h6C3D) begin errors++; $display("FAIL wi_commit: got %h expected 6c3d", dq); end
        idle_pins();
        step();
    endtask

    task automatic test_alias();
        do_write(18'h00400, 16'hA5A5, 1'b0, 1'b0);
        start_read(18'h00000);
        repeat (L + 1) step();
        checks++; if (dq !== 16'hA5A5) begin errors++; $display("FAIL alias_dq: got %h expected a5a5", dq); end
    endtask

    task automatic test_reset_mid_read();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL rmr_dq: got %h expected ffff", dq); end
        checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL rmr_wr_cnt: got %h expected 0000", wr_cnt); end
        checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL rmr_rd_cnt: got %h expected 0000", rd_cnt); end
        idle_pins();
        #2;
        rst_n = 1'b1;
        wait_clear();
        start_read(18'h00000);
        repeat (L + 1) step();
        checks++; if (dq !== exp_dq()) begin errors++; $display("FAIL rmr_reread: got %h expected %h", dq, exp_dq()); end
        checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL rmr_rd_cnt2: got %h expected 0001", rd_cnt); end
        idle_pins();
        step();
    endtask

    task automatic test_random();
        logic [17:0] cur;
        int          r;
        for (int a = 0; a < 1024; a++) begin
            do_write({8'($urandom_range(0, 255)), 10'(a)}, 16'($urandom), 1'b0, 1'b0);
        end
        checks++; if (wr_cnt !== exp_wr) begin errors++; $display("FAIL sweep_wr_cnt: got %h expected %h", wr_cnt, exp_wr); end
        cur = 18'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                cur = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 10'($urandom_range(0, 3))};
            end
            r      = $urandom_range(0, 9);
            ce_n   = (r == 2);
            oe_n   = (r == 3);
            we_n   = (r >= 2) ? 1'b1 : 1'b0;
            ub_n   = ($urandom_range(0, 4) == 0);
            lb_n   = ($urandom_range(0, 4) == 0);
            addr   = cur;
            tb_drv = (r < 2);
            tb_data = 16'($urandom);
            #1;
            if (!tb_drv) begin
                checks++; if (dq !== exp_dq()) begin errors++; $display("FAIL rnd_comb_dq[%0d]: got %h expected %h", i, dq, exp_dq()); end
            end
            step();
            checks++; if (wr_cnt !== exp_wr) begin errors++; $display("FAIL rnd_wr_cnt[%0d]: got %h expected %h", i, wr_cnt, exp_wr); end
            checks++; if (rd_cnt !== exp_rd) begin errors++; $display("FAIL rnd_rd_cnt[%0d]: got %h expected %h", i, rd_cnt, exp_rd); end
            if (!tb_drv) begin
                checks++; if (dq !== exp_dq()) begin errors++; $display("FAIL rnd_dq[%0d]: got %h expected %h", i, dq, exp_dq()); end
            end
        end
        idle_pins();
        step();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        prev_addr = '0;
        addr      = '0;
        tb_data   = '0;
        rst_n     = 1'b0;
        idle_pins();
        model_reset();
        test_reset();
        test_full_word();
        test_byte_lane();
        test_addr_change();
        test_write_interrupt();
        test_alias();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
